// File: rtl/k12a_spi_arbiter.sv
// ---------------------------------------------------------------------------
// k12a_spi_arbiter
//   Shares the single k12a SPI byte engine between NUM_REQ byte requesters.
//   Owns one active-low chip select per requester, sequences CS setup,
//   engine load/begin and completion, keeps CS low across multi-byte bursts
//   and grants round-robin between bursts.
//
// Optional feature macro: K12A_SPI_ARB_TIMEOUT_EN
//   When defined, a watchdog aborts a byte that stays busy for TIMEOUT XFER
//   cycles (ack with rx_data = 8'hFF) and the timeout_err port is present.
//
// Ports:
//   clock        system clock, rising edge
//   reset_n      synchronous reset, active-low
//   req          per-requester byte request, held until ack
//   req_last     requested byte is the last of the burst
//   req_tx_data  byte to send, slice i belongs to requester i
//   ack          one-cycle pulse per requester, rx_data valid
//   rx_data      received byte, held until the next ack
//   grant        one-hot engine owner, zero when idle
//   spi_cs_n     chip selects, active-low
//   eng_tx_data  byte to engine data register (zero outside LOAD)
//   eng_tx_load  engine data-register store strobe
//   eng_begin    engine transfer start strobe
//   eng_busy     engine not idle
//   eng_rx_data  engine data register contents
//   arb_busy     arbiter not idle
//   timeout_err  (optional) set on watchdog expiry, cleared by next good ack
// ---------------------------------------------------------------------------
module k12a_spi_arbiter #(
    parameter int unsigned NUM_REQ  = 2,
    parameter int unsigned CS_SETUP = 1,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ-1:0]   req_last,
    input  logic [8*NUM_REQ-1:0] req_tx_data,
    output logic [NUM_REQ-1:0]   ack,
    output logic [7:0]           rx_data,
    output logic [NUM_REQ-1:0]   grant,
    output logic [NUM_REQ-1:0]   spi_cs_n,
    output logic [7:0]           eng_tx_data,
    output logic                 eng_tx_load,
    output logic                 eng_begin,
    input  logic                 eng_busy,
    input  logic [7:0]           eng_rx_data,
    output logic                 arb_busy
`ifdef K12A_SPI_ARB_TIMEOUT_EN
    ,
    output logic                 timeout_err
`endif
);

    localparam int unsigned IW = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 4) begin : g_bad_num_req
        $error("k12a_spi_arbiter: NUM_REQ must be 2..4");
    end
    if (CS_SETUP < 1 || CS_SETUP > 15) begin : g_bad_cs_setup
        $error("k12a_spi_arbiter: CS_SETUP must be 1..15");
    end
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("k12a_spi_arbiter: TIMEOUT must be 1..255");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_LOAD,
        S_XFER,
        S_HOLD,
        S_RELEASE
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [NUM_REQ-1:0]   r_grant;
    logic [NUM_REQ-1:0]   r_cs_n;
    logic [IW-1:0]        r_wi;      // index of current owner
    logic [IW-1:0]        r_ptr;     // last winner, search starts after it
    logic [3:0]           r_cnt;
    logic                 r_last;
    logic                 r_first;   // first XFER cycle, engine busy not yet valid
    logic [NUM_REQ-1:0]   r_ack;
    logic [7:0]           r_rx;

    logic                 w_found;
    logic [IW-1:0]        w_win;
    logic [NUM_REQ-1:0]   w_win_oh;
    logic [NUM_REQ-1:0]   w_wi_oh;
    logic [7:0]           w_tx;
    logic                 w_done;
    logic                 w_tmo;

`ifdef K12A_SPI_ARB_TIMEOUT_EN
    logic [7:0]           r_wd;
    logic                 r_terr;

    assign w_tmo       = (r_state == S_XFER) && eng_busy && (r_wd == 8'(TIMEOUT - 1));
    assign timeout_err = r_terr;
`else
    assign w_tmo       = 1'b0;
`endif

    // Round-robin search: first requesting index after the last winner.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            if (!w_found && req[IW'((32'(r_ptr) + i) % NUM_REQ)]) begin
                w_found = 1'b1;
                w_win   = IW'((32'(r_ptr) + i) % NUM_REQ);
            end
        end
    end

    always_comb begin
        w_tx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (r_wi == IW'(i)) w_tx = req_tx_data[8*i +: 8];
        end
    end

    assign w_win_oh = NUM_REQ'(1) << w_win;
    assign w_wi_oh  = NUM_REQ'(1) << r_wi;
    assign w_done   = (r_state == S_XFER) && !r_first && !eng_busy;

    always_ff @(posedge clock) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        eng_tx_load = 1'b0;
        eng_begin   = 1'b0;
        eng_tx_data = '0;
        case (r_state)
            S_IDLE:    if (w_found && !eng_busy) w_next = S_SETUP;
            S_SETUP:   if (r_cnt == '0) w_next = S_LOAD;
            S_LOAD: begin
                eng_tx_load = 1'b1;
                eng_begin   = 1'b1;
                eng_tx_data = w_tx;
                w_next      = S_XFER;
            end
            S_XFER: begin
                if (w_done)     w_next = r_last ? S_RELEASE : S_HOLD;
                else if (w_tmo) w_next = S_RELEASE;
            end
            // HOLD is entered together with the ack pulse; the requester's
            // decision is only taken in the cycle after that pulse.
            S_HOLD:    if (r_ack == '0) w_next = req[r_wi] ? S_LOAD : S_RELEASE;
            S_RELEASE: w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_grant <= '0;
            r_cs_n  <= '1;
            r_wi    <= '0;
            r_ptr   <= IW'(NUM_REQ - 1);
            r_cnt   <= '0;
            r_last  <= 1'b0;
            r_first <= 1'b0;
            r_ack   <= '0;
            r_rx    <= '0;
        end else begin
            r_ack   <= '0;
            r_first <= (r_state == S_LOAD);
            case (r_state)
                S_IDLE: begin
                    if (w_next == S_SETUP) begin
                        r_grant <= w_win_oh;
                        r_cs_n  <= ~w_win_oh;
                        r_wi    <= w_win;
                        r_cnt   <= 4'(CS_SETUP);
                    end
                end
                S_SETUP:   if (r_cnt != '0) r_cnt <= r_cnt - 4'd1;
                S_LOAD:    r_last <= req_last[r_wi];
                S_XFER: begin
                    if (w_done) begin
                        r_ack <= w_wi_oh;
                        r_rx  <= eng_rx_data;
                    end else if (w_tmo) begin
                        r_ack <= w_wi_oh;
                        r_rx  <= 8'hFF;
                    end
                end
                S_RELEASE: begin
                    r_grant <= '0;
                    r_cs_n  <= '1;
                    r_ptr   <= r_wi;
                end
                default: ;
            endcase
        end
    end

`ifdef K12A_SPI_ARB_TIMEOUT_EN
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_wd   <= '0;
            r_terr <= 1'b0;
        end else begin
            if (r_state == S_LOAD)      r_wd <= '0;
            else if (r_state == S_XFER) r_wd <= r_wd + 8'd1;
            if (w_tmo)       r_terr <= 1'b1;
            else if (w_done) r_terr <= 1'b0;
        end
    end
`endif

    assign ack      = r_ack;
    assign rx_data  = r_rx;
    assign grant    = r_grant;
    assign spi_cs_n = r_cs_n;
    assign arb_busy = (r_state != S_IDLE);

endmodule

// File: tb/tb_k12a_spi_arbiter.sv
// ---------------------------------------------------------------------------
// tb_k12a_spi_arbiter
//   Bench for k12a_spi_arbiter with a small behavioural SPI engine.
//   The engine returns ~tx ^ 8'h66 for every byte it shifts.
//   Expected loads and acks are queued when requests are driven and popped
//   by a monitor when the arbiter produces them.
//   Timeout scenario is built only with K12A_SPI_ARB_TIMEOUT_EN.
// ---------------------------------------------------------------------------
module tb_k12a_spi_arbiter;

    localparam int unsigned NR    = 2;
    localparam int unsigned SETUP = 2;
    localparam int unsigned TMO   = 20;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  req = '0;
    logic [1:0]  req_last = '0;
    logic [15:0] req_tx_data = '0;
    logic [1:0]  ack;
    logic [7:0]  rx_data;
    logic [1:0]  grant;
    logic [1:0]  spi_cs_n;
    logic [7:0]  eng_tx_data;
    logic        eng_tx_load;
    logic        eng_begin;
    logic        eng_busy;
    logic [7:0]  eng_rx_data;
    logic        arb_busy;
`ifdef K12A_SPI_ARB_TIMEOUT_EN
    logic        timeout_err;
`endif

    k12a_spi_arbiter #(
        .NUM_REQ  (NR),
        .CS_SETUP (SETUP),
        .TIMEOUT  (TMO)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .req         (req),
        .req_last    (req_last),
        .req_tx_data (req_tx_data),
        .ack         (ack),
        .rx_data     (rx_data),
        .grant       (grant),
        .spi_cs_n    (spi_cs_n),
        .eng_tx_data (eng_tx_data),
        .eng_tx_load (eng_tx_load),
        .eng_begin   (eng_begin),
        .eng_busy    (eng_busy),
        .eng_rx_data (eng_rx_data),
        .arb_busy    (arb_busy)
`ifdef K12A_SPI_ARB_TIMEOUT_EN
        ,
        .timeout_err (timeout_err)
`endif
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Behavioural engine: busy for eng_lat cycles after begin, freezable.
    logic        e_busy = 1'b0;
    logic [7:0]  e_rx = '0;
    int          e_cnt = 0;
    int          eng_lat = 3;
    logic        eng_stuck = 1'b0;
    assign eng_busy    = e_busy;
    assign eng_rx_data = e_rx;

    always @(posedge clock) begin
        if (eng_begin) begin
            e_busy <= 1'b1;
            e_cnt  <= eng_lat;
            e_rx   <= ~eng_tx_data ^ 8'h66;
        end else if (e_busy && !eng_stuck) begin
            if (e_cnt <= 1) e_busy <= 1'b0;
            else            e_cnt  <= e_cnt - 1;
        end
    end

    function automatic logic [7:0] rx_of(input logic [7:0] b);
        return ~b ^ 8'h66;
    endfunction

    typedef struct {
        int unsigned idx;
        logic [7:0]  dat;
    } item_t;

    item_t q_tx[$];
    item_t q_ack[$];

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    // Scoreboard monitor and always-on invariants.
    item_t      mon_it;
    logic [1:0] mon_exp;
    always @(negedge clock) begin
        if (reset_n === 1'b1) begin
            n_cmp++;
            if (spi_cs_n !== ~grant || $countones(grant) > 1) begin
                n_err++;
                $display("FAIL cs_grant_onehot: cs_n=%b grant=%b", spi_cs_n, grant);
            end
            if (eng_tx_load !== 1'b1) begin
                n_cmp++;
                if (eng_tx_data !== 8'h00 || eng_begin !== 1'b0) begin
                    n_err++;
                    $display("FAIL idle_eng_outputs: tx_data=%h begin=%b required 00/0", eng_tx_data, eng_begin);
                end
            end else if (q_tx.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL unexpected_load: tx_data=%h grant=%b", eng_tx_data, grant);
            end else begin
                mon_it  = q_tx.pop_front();
                mon_exp = 2'b01 << mon_it.idx;
                n_cmp++;
                if (eng_tx_data !== mon_it.dat || eng_begin !== 1'b1 || grant !== mon_exp) begin
                    n_err++;
                    $display("FAIL load: tx=%h begin=%b grant=%b required tx=%h begin=1 grant=%b",
                             eng_tx_data, eng_begin, grant, mon_it.dat, mon_exp);
                end
            end
            if (ack !== 2'b00) begin
                n_cmp++;
                if (q_ack.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_ack: ack=%b rx=%h", ack, rx_data);
                end else begin
                    mon_it  = q_ack.pop_front();
                    mon_exp = 2'b01 << mon_it.idx;
                    if (ack !== mon_exp || rx_data !== mon_it.dat) begin
                        n_err++;
                        $display("FAIL ack: ack=%b rx=%h required ack=%b rx=%h",
                                 ack, rx_data, mon_exp, mon_it.dat);
                    end
                end
            end
        end
    end

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        n_cmp++;
        if (grant !== 2'b00 || spi_cs_n !== 2'b11 || ack !== 2'b00) begin
            n_err++;
            $display("FAIL reset_ctrl: grant=%b cs_n=%b ack=%b required 00/11/00", grant, spi_cs_n, ack);
        end
        n_cmp++;
        if (eng_tx_load !== 1'b0 || eng_begin !== 1'b0 || rx_data !== 8'h00 || arb_busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_eng: load=%b begin=%b rx=%h busy=%b required 0/0/00/0",
                     eng_tx_load, eng_begin, rx_data, arb_busy);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_single();
        int t_cs = -1, t_ld = -1, t_ack = -1;
        q_tx.push_back('{idx: 0, dat: 8'hA5});
        q_ack.push_back('{idx: 0, dat: 8'h3C});
        req_tx_data[7:0] = 8'hA5;
        req_last[0] = 1'b1;
        req[0] = 1'b1;
        for (int unsigned n = 0; n < 100; n++) begin
            @(negedge clock);
            if (t_cs < 0 && spi_cs_n[0] === 1'b0) t_cs = cyc;
            if (eng_tx_load === 1'b1) t_ld = cyc;
            if (ack[0] === 1'b1) begin
                t_ack = cyc;
                req[0] = 1'b0;
                break;
            end
        end
        n_cmp++;
        if (t_ack < 0) begin
            n_err++;
            $display("FAIL single_ack_wait: no ack within 100 cycles");
        end
        n_cmp++;
        if (t_ld - t_cs != int'(SETUP + 1)) begin
            n_err++;
            $display("FAIL single_cs_to_load: got %0d cycles required %0d", t_ld - t_cs, SETUP + 1);
        end
        @(negedge clock);
        n_cmp++;
        if (spi_cs_n !== 2'b11 || grant !== 2'b00 || ack !== 2'b00 || arb_busy !== 1'b0) begin
            n_err++;
            $display("FAIL single_release: cs_n=%b grant=%b ack=%b busy=%b required 11/00/00/0",
                     spi_cs_n, grant, ack, arb_busy);
        end
        n_cmp++;
        if (rx_data !== 8'h3C) begin
            n_err++;
            $display("FAIL single_rx_hold: got %h required 3c", rx_data);
        end
    endtask

    task automatic test_burst();
        logic [7:0] bytes [3];
        int t_cs = -1;
        int t_ld [3];
        int t_ack [3];
        int nld = 0, nack = 0;
        logic started = 1'b0, cs_break = 1'b0;
        bytes[0] = 8'h01; bytes[1] = 8'h02; bytes[2] = 8'h03;
        for (int i = 0; i < 3; i++) begin
            t_ld[i] = -1; t_ack[i] = -1;
            q_tx.push_back('{idx: 1, dat: bytes[i]});
            q_ack.push_back('{idx: 1, dat: rx_of(bytes[i])});
        end
        req_tx_data[15:8] = bytes[0];
        req_last[1] = 1'b0;
        req[1] = 1'b1;
        for (int unsigned n = 0; n < 200; n++) begin
            @(negedge clock);
            if (!started && spi_cs_n[1] === 1'b0) begin
                started = 1'b1;
                t_cs = cyc;
            end else if (started && spi_cs_n[1] !== 1'b0) begin
                cs_break = 1'b1;
            end
            if (eng_tx_load === 1'b1 && nld < 3) begin
                t_ld[nld] = cyc;
                nld++;
            end
            if (ack[1] === 1'b1) begin
                t_ack[nack] = cyc;
                nack++;
                if (nack < 3) begin
                    req_tx_data[15:8] = bytes[nack];
                    req_last[1] = (nack == 2);
                end else begin
                    req[1] = 1'b0;
                    break;
                end
            end
        end
        n_cmp++;
        if (nack != 3 || nld != 3) begin
            n_err++;
            $display("FAIL burst_counts: acks=%0d loads=%0d required 3/3", nack, nld);
        end
        n_cmp++;
        if (cs_break) begin
            n_err++;
            $display("FAIL burst_cs_low: cs_n[1] rose mid-burst, required continuously 0");
        end
        n_cmp++;
        if (t_ld[0] - t_cs != int'(SETUP + 1)) begin
            n_err++;
            $display("FAIL burst_setup: got %0d required %0d", t_ld[0] - t_cs, SETUP + 1);
        end
        n_cmp++;
        if (t_ld[1] - t_ack[0] != 2 || t_ld[2] - t_ack[1] != 2) begin
            n_err++;
            $display("FAIL burst_ack_to_load: got %0d,%0d required 2,2", t_ld[1] - t_ack[0], t_ld[2] - t_ack[1]);
        end
        @(negedge clock);
        n_cmp++;
        if (spi_cs_n[1] !== 1'b1 || grant !== 2'b00) begin
            n_err++;
            $display("FAIL burst_release: cs_n=%b grant=%b required 11/00", spi_cs_n, grant);
        end
    endtask

    task automatic test_abandon();
        logic got = 1'b0;
        logic [2:0] cs_seq;
        int begins = 0;
        q_tx.push_back('{idx: 0, dat: 8'h5A});
        q_ack.push_back('{idx: 0, dat: rx_of(8'h5A)});
        req_tx_data[7:0] = 8'h5A;
        req_last[0] = 1'b0;
        req[0] = 1'b1;
        for (int unsigned n = 0; n < 100; n++) begin
            @(negedge clock);
            if (ack[0] === 1'b1) begin
                got = 1'b1;
                req[0] = 1'b0;
                break;
            end
        end
        n_cmp++;
        if (!got) begin
            n_err++;
            $display("FAIL abandon_ack_wait: no ack within 100 cycles");
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (i < 3) cs_seq[i] = spi_cs_n[0];
            if (eng_begin === 1'b1) begins++;
        end
        n_cmp++;
        if (cs_seq[0] !== 1'b0 || cs_seq[2] !== 1'b1) begin
            n_err++;
            $display("FAIL abandon_cs: hold=%b after_release=%b required 0/1", cs_seq[0], cs_seq[2]);
        end
        n_cmp++;
        if (begins != 0 || arb_busy !== 1'b0) begin
            n_err++;
            $display("FAIL abandon_no_begin: begins=%0d busy=%b required 0/0", begins, arb_busy);
        end
    endtask

    task automatic test_contention();
        logic [7:0] b0 [2];
        logic [7:0] b1 [2];
        int order [4];
        int k0 = 0, k1 = 0, ng = 0;
        logic gap_err = 1'b0;
        logic [1:0] prev_cs, fell;
        b0[0] = 8'h10; b0[1] = 8'h11; b1[0] = 8'h20; b1[1] = 8'h21;
        // A fresh reset must put requester 0 first again.
        @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            q_tx.push_back('{idx: 0, dat: b0[i]});
            q_ack.push_back('{idx: 0, dat: rx_of(b0[i])});
            q_tx.push_back('{idx: 1, dat: b1[i]});
            q_ack.push_back('{idx: 1, dat: rx_of(b1[i])});
        end
        for (int i = 0; i < 4; i++) order[i] = -1;
        req_tx_data = {b1[0], b0[0]};
        req_last = 2'b11;
        prev_cs = spi_cs_n;
        req = 2'b11;
        for (int unsigned n = 0; n < 400; n++) begin
            @(negedge clock);
            fell = prev_cs & ~spi_cs_n;
            if (fell != 2'b00) begin
                if (prev_cs !== 2'b11) gap_err = 1'b1;
                if (ng < 4) order[ng] = fell[1] ? 1 : 0;
                ng++;
            end
            prev_cs = spi_cs_n;
            if (ack[0] === 1'b1) begin
                k0++;
                if (k0 < 2) req_tx_data[7:0] = b0[k0]; else req[0] = 1'b0;
            end
            if (ack[1] === 1'b1) begin
                k1++;
                if (k1 < 2) req_tx_data[15:8] = b1[k1]; else req[1] = 1'b0;
            end
            if (k0 == 2 && k1 == 2) break;
        end
        n_cmp++;
        if (k0 != 2 || k1 != 2 || ng != 4) begin
            n_err++;
            $display("FAIL contention_counts: acks0=%0d acks1=%0d grants=%0d required 2/2/4", k0, k1, ng);
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (order[i] != i % 2) begin
                n_err++;
                $display("FAIL contention_order[%0d]: got %0d required %0d", i, order[i], i % 2);
            end
        end
        n_cmp++;
        if (gap_err) begin
            n_err++;
            $display("FAIL contention_gap: a CS fell without a cycle of all CS high, required gap");
        end
    endtask

    task automatic test_reset_mid();
        logic got = 1'b0, prev_busy = 1'b1, early = 1'b0;
        int early_grants = 0;
        eng_stuck = 1'b1;
        q_tx.push_back('{idx: 0, dat: 8'h77});
        req_tx_data[7:0] = 8'h77;
        req_last[0] = 1'b1;
        req[0] = 1'b1;
        for (int unsigned n = 0; n < 100; n++) begin
            @(negedge clock);
            if (eng_tx_load === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        repeat (2) @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        n_cmp++;
        if (!got || spi_cs_n !== 2'b11 || grant !== 2'b00 || ack !== 2'b00 || arb_busy !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_state: loaded=%b cs_n=%b grant=%b ack=%b busy=%b required 1/11/00/00/0",
                     got, spi_cs_n, grant, ack, arb_busy);
        end
        n_cmp++;
        if (rx_data !== 8'h00) begin
            n_err++;
            $display("FAIL midreset_rx: got %h required 00", rx_data);
        end
        q_tx.delete();
        q_ack.delete();
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (grant !== 2'b00) early_grants++;
        end
        n_cmp++;
        if (early_grants != 0) begin
            n_err++;
            $display("FAIL midreset_wait_busy: %0d granted cycles while engine busy, required 0", early_grants);
        end
        q_tx.push_back('{idx: 0, dat: 8'h78});
        q_ack.push_back('{idx: 0, dat: rx_of(8'h78)});
        req_tx_data[7:0] = 8'h78;
        eng_stuck = 1'b0;
        got = 1'b0;
        prev_busy = eng_busy;
        for (int unsigned n = 0; n < 100; n++) begin
            @(negedge clock);
            if (grant !== 2'b00 && prev_busy === 1'b1 && !got) early = 1'b1;
            if (grant !== 2'b00) got = 1'b1;
            prev_busy = eng_busy;
            if (ack[0] === 1'b1) begin
                req[0] = 1'b0;
                break;
            end
        end
        n_cmp++;
        if (!got || early) begin
            n_err++;
            $display("FAIL midreset_regrant: granted=%b while_busy=%b required 1/0", got, early);
        end
        repeat (3) @(negedge clock);
    endtask

`ifdef K12A_SPI_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int t_ld = -1, t_ack = -1;
        logic terr_at_ack = 1'b0;
        eng_stuck = 1'b1;
        q_tx.push_back('{idx: 0, dat: 8'hC3});
        q_ack.push_back('{idx: 0, dat: 8'hFF});
        req_tx_data[7:0] = 8'hC3;
        req_last[0] = 1'b1;
        req[0] = 1'b1;
        for (int unsigned n = 0; n < 200; n++) begin
            @(negedge clock);
            if (eng_tx_load === 1'b1) t_ld = cyc;
            if (ack[0] === 1'b1) begin
                t_ack = cyc;
                terr_at_ack = timeout_err;
                req[0] = 1'b0;
                break;
            end
        end
        n_cmp++;
        if (t_ack - t_ld != int'(TMO + 1) || t_ld < 0) begin
            n_err++;
            $display("FAIL timeout_latency: load->ack got %0d required %0d", t_ack - t_ld, TMO + 1);
        end
        n_cmp++;
        if (terr_at_ack !== 1'b1) begin
            n_err++;
            $display("FAIL timeout_err_set: got %b required 1", terr_at_ack);
        end
        @(negedge clock);
        n_cmp++;
        if (spi_cs_n !== 2'b11 || grant !== 2'b00 || timeout_err !== 1'b1) begin
            n_err++;
            $display("FAIL timeout_release: cs_n=%b grant=%b err=%b required 11/00/1", spi_cs_n, grant, timeout_err);
        end
        eng_stuck = 1'b0;
        q_tx.push_back('{idx: 0, dat: 8'h42});
        q_ack.push_back('{idx: 0, dat: rx_of(8'h42)});
        req_tx_data[7:0] = 8'h42;
        req[0] = 1'b1;
        terr_at_ack = 1'b1;
        t_ack = -1;
        for (int unsigned n = 0; n < 200; n++) begin
            @(negedge clock);
            if (ack[0] === 1'b1) begin
                t_ack = cyc;
                terr_at_ack = timeout_err;
                req[0] = 1'b0;
                break;
            end
        end
        n_cmp++;
        if (t_ack < 0 || terr_at_ack !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_err_clear: acked=%b err=%b required 1/0", t_ack >= 0, terr_at_ack);
        end
        repeat (3) @(negedge clock);
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_abandon();
        test_contention();
        test_reset_mid();
`ifdef K12A_SPI_ARB_TIMEOUT_EN
        test_timeout();
`endif
        repeat (2) @(negedge clock);
        n_cmp++;
        if (q_tx.size() != 0 || q_ack.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: loads_left=%0d acks_left=%0d required 0/0", q_tx.size(), q_ack.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
